// File: rtl/aes_pkg.sv
// Shared AES constants, word/state types and round-constant helpers
// used by the key schedule and the round datapath.
package aes_pkg;

  localparam int AES_NB    = 4;
  localparam int AES128_NR = 10;

  typedef logic [31:0] word_t;

  // States are plain constants so older netlists that probe the state code keep working
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACTIVE = 2'd1;
  localparam state_t DONE   = 2'd2;

  function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box (forward direction); shared by the key schedule
// SubWord and the SubBytes stage.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 is the leftmost byte of the first row
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 on-the-fly key expansion, one round key per i_next.
// Define AES_KEY_SCHED_DEC_KEY_EN to add the o_dec_key round-10 capture register.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [127:0]     i_key,
  input  logic             i_next,
  output logic [127:0]     o_round_key,
  output logic [RND_W-1:0] o_round,
  output logic             o_valid,
  output logic             o_last
`ifdef AES_KEY_SCHED_DEC_KEY_EN
  ,output logic [127:0]    o_dec_key
`endif
);

  state_t           state_q;
  logic [127:0]     key_q;
  logic [RND_W-1:0] round_q;
  logic             valid_q;

  word_t            w0, w1, w2, w3;
  word_t            rot_w, sub_w, t_w;
  word_t            n0, n1, n2, n3;
  logic [127:0]     next_key;
  logic [RND_W-1:0] round_inc;
  logic [3:0]       rcon_idx;
  logic             advance;
  logic             to_last;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w = rot_word(w3);

  for (genvar i = 0; i < AES_NB; i++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (rot_w[8*i +: 8]),
      .o_byte (sub_w[8*i +: 8])
    );
  end

  assign round_inc = round_q + RND_W'(1);
  assign rcon_idx  = 4'(round_inc);
  assign t_w       = sub_w ^ {aes_rcon(rcon_idx), 24'h000000};
  assign n0        = w0 ^ t_w;
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign next_key  = {n0, n1, n2, n3};

  // Load always beats advance; advance only counts while ACTIVE, so DONE holds round 10
  assign advance = i_next && !i_load && (state_q == ACTIVE);
  assign to_last = advance && (round_q == RND_W'(NUM_ROUNDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      state_q <= ACTIVE;
      key_q   <= i_key;
      round_q <= '0;
      valid_q <= 1'b1;
    end else if (advance) begin
      key_q   <= next_key;
      round_q <= round_inc;
      if (to_last) begin
        state_q <= DONE;
      end
    end
  end

`ifdef AES_KEY_SCHED_DEC_KEY_EN
  // Survives reloads so decryption can start from the previous key's last round key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dec_key <= '0;
    end else if (to_last) begin
      o_dec_key <= next_key;
    end
  end
`else
`endif

  assign o_round_key = key_q;
  assign o_round     = round_q;
  assign o_valid     = valid_q;
  assign o_last      = valid_q && (round_q == RND_W'(NUM_ROUNDS));

endmodule
